line_buffer_sequencer: RTL

Controller that sequences one frame of raster-order pixels into the Sobel line-buffer chain. It gates the buffer write-enable, tracks column and row position, and flags when a full 3x3 neighbourhood is available. It sits between the pixel source and the cascaded single-line FIFOs, and feeds the Sobel kernel's window-valid and coordinate inputs.

---
 rtl/sobel_pkg.sv | 19 +
 rtl/pixel_position_counter.sv | 52 +++++
 rtl/line_buffer_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: sequencer state encoding,
// default pixel width and a counter-width helper.
package sobel_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   // Width of a counter that holds 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pixel_position_counter.sv
// Raster position counter for one frame.
// Ports:
//   clk, rst   - clock, async active-high reset
//   clr        - synchronous clear to (0,0)
//   en         - advance one pixel
//   col, row   - current position
//   line_end   - col is the last column
//   frame_end  - position is the last pixel of the frame
module pixel_position_counter
   import sobel_pkg::*;
#(
   parameter int W = 640,
   parameter int H = 480
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   output logic [cnt_w(W)-1:0] col,
   output logic [cnt_w(H)-1:0] row,
   output logic                line_end,
   output logic                frame_end
);

   localparam int CW = cnt_w(W);
   localparam int RW = cnt_w(H);
   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

   assign line_end  = (col == COL_LAST);
   assign frame_end = line_end && (row == ROW_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (line_end) begin
            col <= '0;
            // Wrap the row too so a non-power-of-two height never leaves
            // the counter parked outside the frame.
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/line_buffer_sequencer.sv
// Sequences one raster frame into the Sobel line-buffer chain and flags
// each pixel position whose 3x3 neighbourhood is complete.
// Ports:
//   clk, rst        - clock, async active-high reset
//   start_i         - arm capture of one frame (honoured only in IDLE)
//   pix_valid_i     - pixel present on pix_data_i
//   pix_data_i      - incoming pixel
//   lb_we_o         - line-buffer write enable (combinational)
//   lb_data_o       - pixel passed through to the line buffers
//   win_valid_o     - window centred on (win_row_o, win_col_o) is valid
//   win_row_o       - window centre row
//   win_col_o       - window centre column
//   busy_o          - frame capture in progress
//   frame_done_o    - one-cycle pulse after the last pixel
//
// state | meaning
// IDLE  | waiting for start_i, pixels ignored
// FILL  | priming the first two lines, no windows yet
// RUN   | steady state, windows emitted for row>=2, col>=2
// DONE  | one cycle after the last pixel, frame_done_o high
module line_buffer_sequencer
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic                         pix_valid_i,
   input  logic [DATA_W-1:0]            pix_data_i,
   output logic                         lb_we_o,
   output logic [DATA_W-1:0]            lb_data_o,
   output logic                         win_valid_o,
   output logic [cnt_w(IMG_HEIGHT)-1:0] win_row_o,
   output logic [cnt_w(IMG_WIDTH)-1:0]  win_col_o,
   output logic                         busy_o,
   output logic                         frame_done_o
);

   localparam int CW = cnt_w(IMG_WIDTH);
   localparam int RW = cnt_w(IMG_HEIGHT);

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          line_end;
   logic          frame_end;
   logic          accept;
   logic          clr;
   logic          win_hit;

   assign accept    = pix_valid_i && ((state == ST_FILL) || (state == ST_RUN));
   assign clr       = (state == ST_IDLE) && start_i;
   assign lb_we_o   = accept;
   assign lb_data_o = pix_data_i;

   // Rows 0/1 are never seen in RUN, so only the column edge needs masking
   // in practice; the row term keeps the intent explicit.
   assign win_hit = (state == ST_RUN) && accept &&
                    (row >= RW'(2)) && (col >= CW'(2));

   pixel_position_counter #(
      .W (IMG_WIDTH),
      .H (IMG_HEIGHT)
   ) u_pos (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (accept),
      .col       (col),
      .row       (row),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_i) state_nxt = ST_FILL;
         ST_FILL: if (accept && line_end && (row == RW'(1))) state_nxt = ST_RUN;
         ST_RUN:  if (accept && frame_end) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         win_valid_o  <= 1'b0;
         win_row_o    <= '0;
         win_col_o    <= '0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         win_valid_o  <= win_hit;
         busy_o       <= (state_nxt == ST_FILL) || (state_nxt == ST_RUN);
         frame_done_o <= (state_nxt == ST_DONE);
         if (win_hit) begin
            win_row_o <= row - RW'(1);
            win_col_o <= col - CW'(1);
         end
      end
   end

endmodule
